// File: rtl/seven_seg_refresh_ctrl.sv
// ============================================================================
// Module   : seven_seg_refresh_ctrl
// Brief    : Time-shares one external hex-to-segment decoder across NUM_DIGITS
//            displays. Optional macro: SEVEN_SEG_LEADING_ZERO_BLANK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_seg_refresh_ctrl #(
    parameter int NUM_DIGITS = 6
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      upd_req,
    input  logic [4*NUM_DIGITS-1:0]   upd_val,
    output logic                      busy,
    output logic                      done,
    output logic [3:0]                dec_val,
    input  logic [7:0]                dec_seg,
    output logic [8*NUM_DIGITS-1:0]   HEX_ALL
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DRIVE   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [2:0] LAST_IDX  = 3'(NUM_DIGITS - 1);

    logic [1:0]                state_q,  state_d;
    logic [2:0]                idx_q,    idx_d;
    logic [4*NUM_DIGITS-1:0]   shadow_q, shadow_d;
    logic [8*NUM_DIGITS-1:0]   hex_q,    hex_d;

    logic [3:0]                cur_nib;
    logic [7:0]                cap_seg;

    always_comb begin
        cur_nib = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i)) cur_nib = shadow_q[4*i +: 4];
        end
    end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // Digit 0 is never blanked so a zero value still shows a single "0".
    always_comb begin
        lead_zero = 1'b0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (idx_q == 3'(i) && (shadow_q >> (4*i)) == '0) lead_zero = 1'b1;
        end
    end

    assign cap_seg = lead_zero ? 8'hFF : dec_seg;
`else
    assign cap_seg = dec_seg;
`endif

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idx_q    <= 3'd0;
            shadow_q <= '0;
            hex_q    <= '1;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            hex_q    <= hex_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        hex_d    = hex_q;
        case (state_q)
            S_IDLE: begin
                if (upd_req) begin
                    shadow_d = upd_val;
                    idx_d    = 3'd0;
                    state_d  = S_DRIVE;
                end
            end
            S_DRIVE: state_d = S_CAPTURE;
            S_CAPTURE: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (idx_q == 3'(i)) hex_d[8*i +: 8] = cap_seg;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    state_d = S_DRIVE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        dec_val = 4'h0;
        if (state_q == S_DRIVE || state_q == S_CAPTURE) dec_val = cur_nib;
    end

    assign HEX_ALL = hex_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_seg_refresh_ctrl.sv
// ============================================================================
// Module   : tb_seven_seg_refresh_ctrl
// Brief    : Self-checking bench for seven_seg_refresh_ctrl with a model
//            decoder and a digit-level reference of the refresh sequence.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_seg_refresh_ctrl;

    localparam int N = 6;

    logic          CLOCK_50 = 1'b0;
    logic          reset;
    logic          upd_req;
    logic [23:0]   upd_val;
    logic          busy;
    logic          done;
    logic [3:0]    dec_val;
    logic [7:0]    dec_seg;
    logic [47:0]   HEX_ALL;
    logic [7:0]    dp_x;
    logic [47:0]   exp_hex;

    int total = 0;
    int bad   = 0;

    seven_seg_refresh_ctrl #(.NUM_DIGITS(N)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .upd_req  (upd_req),
        .upd_val  (upd_val),
        .busy     (busy),
        .done     (done),
        .dec_val  (dec_val),
        .dec_seg  (dec_seg),
        .HEX_ALL  (HEX_ALL)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [7:0] seg_of(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
            4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
            4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
            4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
        endcase
    endfunction

    // Model decoder; dp_x optionally lights the decimal point to prove passthrough.
    assign dec_seg = seg_of(dec_val) ^ dp_x;

    function automatic logic [47:0] expect_hex(input logic [23:0] v, input logic [7:0] x);
        logic [47:0] r;
        for (int i = 0; i < N; i++) begin
            r[8*i +: 8] = seg_of(v[4*i +: 4]) ^ x;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
            if (i > 0 && (v >> (4*i)) == 24'd0) r[8*i +: 8] = 8'hFF;
`endif
        end
        return r;
    endfunction

    // Presents a one-cycle request; returns at the falling edge after the accept edge.
    task automatic start(input logic [23:0] v);
        upd_req = 1'b1;
        upd_val = v;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        upd_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; upd_req = 1'b0; upd_val = 24'd0; dp_x = 8'h00;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (10) @(negedge CLOCK_50);
        total++; if (HEX_ALL !== {48{1'b1}}) begin bad++; $display("FAIL reset_hex got=%h exp=%h", HEX_ALL, {48{1'b1}}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (dec_val !== 4'h0) begin bad++; $display("FAIL reset_dec_val got=%h exp=0", dec_val); end
        exp_hex = {48{1'b1}};
    endtask

    task automatic test_basic();
        int ndone = 0;
        int done_m = -1;
        logic [47:0] want;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        want = 48'hFFF9A4B0888E;
`else
        want = 48'hC0F9A4B0888E;
`endif
        dp_x = 8'h00;
        start(24'h0123AF);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
        for (int m = 0; m <= 2*N + 1; m++) begin
            if (done === 1'b1) begin ndone++; done_m = m; end
            @(negedge CLOCK_50);
        end
        total++; if (done_m != 2*N) begin bad++; $display("FAIL basic_done_latency got=%0d exp=%0d", done_m, 2*N); end
        total++; if (ndone != 1) begin bad++; $display("FAIL basic_done_count got=%0d exp=1", ndone); end
        total++; if (HEX_ALL !== want) begin bad++; $display("FAIL basic_hex got=%h exp=%h", HEX_ALL, want); end
        exp_hex = want;
    endtask

    task automatic test_random();
        for (int t = 0; t < 8; t++) begin
            logic [23:0] v;
            logic [47:0] nxt;
            logic [47:0] cur;
            v    = 24'($urandom);
            dp_x = ($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00;
            nxt  = expect_hex(v, dp_x);
            start(v);
            for (int m = 0; m <= 2*N + 1; m++) begin
                for (int i = 0; i < N; i++)
                    cur[8*i +: 8] = (2*i + 2 <= m) ? nxt[8*i +: 8] : exp_hex[8*i +: 8];
                total++; if (HEX_ALL !== cur) begin bad++; $display("FAIL rand_hex t=%0d m=%0d got=%h exp=%h", t, m, HEX_ALL, cur); end
                total++; if (busy !== 1'(m <= 2*N)) begin bad++; $display("FAIL rand_busy t=%0d m=%0d got=%b", t, m, busy); end
                total++; if (done !== 1'(m == 2*N)) begin bad++; $display("FAIL rand_done t=%0d m=%0d got=%b", t, m, done); end
                if (m < 2*N) begin
                    total++;
                    if (dec_val !== v[4*(m/2) +: 4]) begin
                        bad++; $display("FAIL rand_dec_val t=%0d m=%0d got=%h exp=%h", t, m, dec_val, v[4*(m/2) +: 4]);
                    end
                end
                upd_val = 24'($urandom);
                @(negedge CLOCK_50);
            end
            exp_hex = nxt;
        end
    endtask

    task automatic test_ignore_busy();
        logic [23:0] v;
        int ndone = 0;
        v = 24'($urandom);
        dp_x = 8'h00;
        start(v);
        for (int m = 0; m < 2*N + 8; m++) begin
            if (done === 1'b1) ndone++;
            upd_req = (m == 3);
            if (m >= 3) upd_val = ~v;
            @(negedge CLOCK_50);
        end
        upd_req = 1'b0;
        total++; if (ndone != 1) begin bad++; $display("FAIL busy_done_count got=%0d exp=1", ndone); end
        total++; if (HEX_ALL !== expect_hex(v, 8'h00)) begin bad++; $display("FAIL busy_hex got=%h exp=%h", HEX_ALL, expect_hex(v, 8'h00)); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle_after got=%b exp=0", busy); end
        exp_hex = expect_hex(v, 8'h00);
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int ndone = 0;
        logic prev_busy = 1'b0;
        logic [23:0] v;
        v = 24'($urandom);
        dp_x = 8'h00;
        upd_val = v;
        upd_req = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge CLOCK_50);
            if (busy === 1'b1 && prev_busy === 1'b0) acc.push_back(c);
            if (done === 1'b1) ndone++;
            prev_busy = busy;
            if (c == 39) upd_req = 1'b0;
        end
        total++; if (acc.size() != 3) begin bad++; $display("FAIL b2b_accepts got=%0d exp=3", acc.size()); end
        for (int i = 1; i < acc.size(); i++) begin
            total++;
            if (acc[i] - acc[i-1] != 2*N + 2) begin
                bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc[i] - acc[i-1], 2*N + 2);
            end
        end
        total++; if (ndone != 3) begin bad++; $display("FAIL b2b_done_count got=%0d exp=3", ndone); end
        total++; if (HEX_ALL !== expect_hex(v, 8'h00)) begin bad++; $display("FAIL b2b_hex got=%h exp=%h", HEX_ALL, expect_hex(v, 8'h00)); end
        exp_hex = expect_hex(v, 8'h00);
    endtask

    task automatic test_reset_mid();
        logic [23:0] v, v2;
        logic [47:0] nxt, cur;
        int ndone = 0;
        v = 24'($urandom);
        v2 = 24'($urandom);
        dp_x = 8'h00;
        nxt = expect_hex(v, 8'h00);
        start(v);
        repeat (6) @(negedge CLOCK_50);
        cur = {exp_hex[47:24], nxt[23:0]};
        total++; if (HEX_ALL !== cur) begin bad++; $display("FAIL rstmid_partial got=%h exp=%h", HEX_ALL, cur); end
        #2 reset = 1'b1;
        #1;
        total++; if (HEX_ALL !== {48{1'b1}}) begin bad++; $display("FAIL rstmid_blank got=%h exp=%h", HEX_ALL, {48{1'b1}}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
        @(negedge CLOCK_50);
        reset = 1'b0;
        exp_hex = {48{1'b1}};
        for (int c = 0; c < 2*N + 4; c++) begin
            if (done === 1'b1) ndone++;
            @(negedge CLOCK_50);
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
        start(v2);
        total++; if (dec_val !== v2[3:0]) begin bad++; $display("FAIL rstmid_restart_digit0 got=%h exp=%h", dec_val, v2[3:0]); end
        repeat (2*N + 2) @(negedge CLOCK_50);
        total++; if (HEX_ALL !== expect_hex(v2, 8'h00)) begin bad++; $display("FAIL rstmid_restart_hex got=%h exp=%h", HEX_ALL, expect_hex(v2, 8'h00)); end
        exp_hex = expect_hex(v2, 8'h00);
    endtask

    task automatic test_zero_values();
        logic [23:0] vals [2];
        logic [47:0] want [2];
        vals[0] = 24'h000120;
        vals[1] = 24'h000000;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        want[0] = 48'hFFFFFFF9A4C0;
        want[1] = 48'hFFFFFFFFFFC0;
`else
        want[0] = 48'hC0C0C0F9A4C0;
        want[1] = 48'hC0C0C0C0C0C0;
`endif
        dp_x = 8'h00;
        for (int k = 0; k < 2; k++) begin
            start(vals[k]);
            repeat (2*N + 2) @(negedge CLOCK_50);
            total++; if (HEX_ALL !== want[k]) begin bad++; $display("FAIL zero_hex k=%0d got=%h exp=%h", k, HEX_ALL, want[k]); end
            exp_hex = want[k];
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        test_zero_values();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
